arbitro_vc_destinos: RTL

Weighted arbiter that drains the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the transmission layer. It grants one word per cycle to a VC, routes that word to D0 or D1 by destination bit, and withholds a grant while the target destination is almost full. Its `enable` input is driven by the main flow-control FSM's `active_out`.

---
 rtl/arbitro_vc_destinos_if.sv | 32 +++
 rtl/arbitro_vc_destinos.sv | 137 +++++++++++++
 2 files changed

// File: rtl/arbitro_vc_destinos_if.sv
// Bundle of the VC-to-destination arbiter signals: VC FIFO side, destination FIFO side
// and the flow-control inputs. The slave modport is the arbiter's view.
interface arbitro_vc_destinos_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  enable;
    logic [3:0]            peso_vc0;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_push;
    logic                  d1_push;
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            estado;

    modport slave (
        input  enable, peso_vc0, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, data_out, estado
    );

    modport master (
        output enable, peso_vc0, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, estado
    );
endinterface

// File: rtl/arbitro_vc_destinos.sv
// Weighted arbiter draining VC0/VC1 into destination FIFOs D0/D1: combinational pops,
// registered push stage one cycle later, head word bit data_width-2 picks the destination.
module arbitro_vc_destinos #(
    parameter int data_width = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    arbitro_vc_destinos_if.slave   bus
);
    localparam int DEST_BIT = data_width - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SERVE_VC0 = 2'b01,
        SERVE_VC1 = 2'b10
    } estado_t;

    // Almost-full flag of whichever destination a head word targets.
    function automatic logic dest_af(input logic dest_sel, input logic af0, input logic af1);
        logic r;
        if (dest_sel) begin
            r = af1;
        end else begin
            r = af0;
        end
        return r;
    endfunction

    logic                  elig0_s;
    logic                  elig1_s;
    logic                  grant0_s;
    logic                  grant1_s;
    logic [3:0]            peso_ef_s;
    logic [data_width-1:0] word_s;

    logic [3:0]            cnt_q;
    logic [3:0]            cnt_d;
    estado_t               estado_q;
    estado_t               estado_d;
    logic                  d0_push_q;
    logic                  d0_push_d;
    logic                  d1_push_q;
    logic                  d1_push_d;
    logic [data_width-1:0] data_q;
    logic [data_width-1:0] data_d;

    // Eligibility (head-of-line blocking is intentional) and weighted grant.
    always_comb begin
        elig0_s   = bus.enable & ~bus.vc0_empty &
                    ~dest_af(bus.vc0_data[DEST_BIT], bus.d0_almost_full, bus.d1_almost_full);
        elig1_s   = bus.enable & ~bus.vc1_empty &
                    ~dest_af(bus.vc1_data[DEST_BIT], bus.d0_almost_full, bus.d1_almost_full);
        peso_ef_s = (bus.peso_vc0 == 4'd0) ? 4'd1 : bus.peso_vc0;
        grant0_s  = 1'b0;
        grant1_s  = 1'b0;
        if (elig0_s && elig1_s) begin
            if (cnt_q < peso_ef_s) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (elig0_s) begin
            grant0_s = 1'b1;
        end else if (elig1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Next-state values for credit counter, FSM state and push stage.
    always_comb begin
        cnt_d     = cnt_q;
        estado_d  = IDLE;
        word_s    = bus.vc0_data;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        data_d    = data_q;

        if (grant1_s) begin
            cnt_d = 4'd0;
        end else if (grant0_s && elig1_s) begin
            // Saturate rather than wrap so a large weight never flips back to favouring VC0.
            cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
        end else if (!elig1_s) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q;
        end

        if (grant0_s) begin
            estado_d = SERVE_VC0;
            word_s   = bus.vc0_data;
        end else if (grant1_s) begin
            estado_d = SERVE_VC1;
            word_s   = bus.vc1_data;
        end else begin
            estado_d = IDLE;
            word_s   = bus.vc0_data;
        end

        if (grant0_s || grant1_s) begin
            d0_push_d = ~word_s[DEST_BIT];
            d1_push_d = word_s[DEST_BIT];
            data_d    = word_s;
        end else begin
            d0_push_d = 1'b0;
            d1_push_d = 1'b0;
            data_d    = data_q;
        end
    end

    // State and registered outputs; reset drops any pending push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 4'd0;
            estado_q  <= IDLE;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            data_q    <= {data_width{1'b0}};
        end else begin
            cnt_q     <= cnt_d;
            estado_q  <= estado_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
            data_q    <= data_d;
        end
    end

    assign bus.vc0_pop  = grant0_s & reset;
    assign bus.vc1_pop  = grant1_s & reset;
    assign bus.d0_push  = d0_push_q;
    assign bus.d1_push  = d1_push_q;
    assign bus.data_out = data_q;
    assign bus.estado   = estado_q;
endmodule
